// File: rtl/skew_feeder.sv
// skew_feeder: buffers one ARRAY_SIZE x ARRAY_SIZE A tile and replays it as a diagonal wavefront.
// Latency: the first wavefront beat is presented the cycle after the last row is accepted.
// Backpressure: in_ready is low for the whole stream; out_ready=0 freezes t and all outputs.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  row stream in; in_data[j] = A[row][j]
//   out_valid/ready wavefront stream out; out_data[i] feeds array row i
//   out_lane_valid  lane i carries a real element (i <= t < i+N)
//   tile_done       pulse on the accepted beat t = 2N-2
//   busy            high while streaming
module skew_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  out_data,
  output logic        [ARRAY_SIZE-1:0]                  out_lane_valid,
  output logic                                          tile_done,
  output logic                                          busy
);

  localparam int LW = $clog2(ARRAY_SIZE);
  localparam int TW = $clog2(2 * ARRAY_SIZE - 1);

  localparam logic [LW-1:0] LAST_ROW  = LW'(ARRAY_SIZE - 1);
  localparam logic [TW-1:0] LAST_BEAT = TW'(2 * ARRAY_SIZE - 2);

  localparam logic [0:0] LOAD   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]                                 state;
  logic [LW-1:0]                              load_cnt;
  logic [TW-1:0]                              t;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]      row_buf [ARRAY_SIZE];
  int                                         kk;

  logic beat_acc;
  assign beat_acc = (state == STREAM) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      load_cnt <= '0;
      t        <= '0;
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        row_buf[r] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            row_buf[load_cnt] <= in_data;
            if (load_cnt == LAST_ROW) begin
              load_cnt <= '0;
              t        <= '0;
              state    <= STREAM;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        default: begin
          // Buffer is frozen here; only the wavefront index moves.
          if (beat_acc) begin
            if (t == LAST_BEAT) begin
              t     <= '0;
              state <= LOAD;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Lane i shows column k = t - i of its own row while 0 <= k < N,
  // which staggers row i by i cycles behind row 0.
  always_comb begin
    out_data       = '0;
    out_lane_valid = '0;
    kk             = 0;
    if (state == STREAM) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        kk = int'(t) - i;
        if ((kk >= 0) && (kk < ARRAY_SIZE)) begin
          out_data[i]       = row_buf[i][kk[LW-1:0]];
          out_lane_valid[i] = 1'b1;
        end
      end
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign tile_done = beat_acc && (t == LAST_BEAT);

endmodule
